// File: rtl/bus_bridge_pkg.sv
// Shared encodings and defaults for the 65C02 bus bridge and its I/O sequencer.
package bus_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } io_state_e;

  localparam logic [7:0] IO_PAGE_DEFAULT = 8'hD0;
  localparam int         TIMEOUT_DEFAULT = 16;
  localparam int         TW_DEFAULT      = 5;

  // Data returned to the core when an I/O access is abandoned.
  localparam logic [7:0] IO_TIMEOUT_DATA = 8'hFF;

  localparam logic DI_SEL_MEM = 1'b0;
  localparam logic DI_SEL_IO  = 1'b1;

endpackage

// File: rtl/bus_io_fsm.sv
// I/O access sequencer: latches the CPU cycle, runs the req/ack handshake with
// a timeout, and holds the returned data plus the sticky timeout flag.
module bus_io_fsm
  import bus_bridge_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT,
  parameter int TW      = TW_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       io_sel,
  input  logic [7:0] addr_lo,
  input  logic [7:0] wdata,
  input  logic       we,
  input  logic       io_ack,
  input  logic [7:0] io_rdata,
  output io_state_e  state,
  output logic [7:0] io_addr,
  output logic [7:0] io_wdata,
  output logic       io_we,
  output logic       io_req,
  output logic       io_err,
  output logic [7:0] io_data
);

  localparam logic [TW-1:0] LAST_COUNT = TW'(TIMEOUT - 1);

  logic [TW-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      count    <= '0;
      io_addr  <= '0;
      io_wdata <= '0;
      io_we    <= 1'b0;
      io_req   <= 1'b0;
      io_err   <= 1'b0;
      io_data  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (io_sel) begin
            io_addr  <= addr_lo;
            io_wdata <= wdata;
            io_we    <= we;
            count    <= '0;
            io_req   <= 1'b1;
            state    <= REQ;
          end
        end
        REQ: begin
          count <= count + TW'(1);
          // An acknowledge in the final allowed cycle still completes normally.
          if (io_ack) begin
            if (!io_we) begin
              io_data <= io_rdata;
            end
            io_req <= 1'b0;
            state  <= DONE;
          end else if (count == LAST_COUNT) begin
            io_err  <= 1'b1;
            io_data <= IO_TIMEOUT_DATA;
            io_req  <= 1'b0;
            state   <= DONE;
          end
        end
        // The core completes the cycle here; the address it still presents
        // must not start another access.
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state  <= IDLE;
          io_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/bus_bridge.sv
// 65C02 bus bridge: zero-wait local memory plus a stalled req/ack I/O page,
// with read data returned to the core one cycle after the address.
module bus_bridge
  import bus_bridge_pkg::*;
#(
  parameter logic [7:0] IO_PAGE = IO_PAGE_DEFAULT,
  parameter int         TIMEOUT = TIMEOUT_DEFAULT,
  parameter int         TW      = TW_DEFAULT
) (
  input  logic        clk,
  input  logic        RST_N,
  input  logic [15:0] AD,
  input  logic [7:0]  DO,
  input  logic        WE,
  output logic [7:0]  DI,
  output logic        RDY,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_we,
  input  logic [7:0]  mem_rdata,
  output logic [7:0]  io_addr,
  output logic [7:0]  io_wdata,
  output logic        io_we,
  output logic        io_req,
  input  logic        io_ack,
  input  logic [7:0]  io_rdata,
  output logic        io_err
);

  logic       io_sel;
  logic       sel_io_q;
  io_state_e  state;
  logic [7:0] io_data;

  assign io_sel = (AD[15:8] == IO_PAGE);

  // Stall from the first sight of an I/O address until the DONE cycle.
  assign RDY = (state == DONE) || ((state == IDLE) && !io_sel);

  assign mem_addr  = AD;
  assign mem_wdata = DO;
  assign mem_we    = WE & ~io_sel & RDY;

  bus_io_fsm #(
    .TIMEOUT (TIMEOUT),
    .TW      (TW)
  ) u_io_fsm (
    .clk      (clk),
    .rst_n    (RST_N),
    .io_sel   (io_sel),
    .addr_lo  (AD[7:0]),
    .wdata    (DO),
    .we       (WE),
    .io_ack   (io_ack),
    .io_rdata (io_rdata),
    .state    (state),
    .io_addr  (io_addr),
    .io_wdata (io_wdata),
    .io_we    (io_we),
    .io_req   (io_req),
    .io_err   (io_err),
    .io_data  (io_data)
  );

  // Remember which source completed the last cycle; a stall keeps it.
  always_ff @(posedge clk or negedge RST_N) begin
    if (!RST_N) begin
      sel_io_q <= DI_SEL_MEM;
    end else if (RDY) begin
      sel_io_q <= (state == DONE) ? DI_SEL_IO : DI_SEL_MEM;
    end
  end

  assign DI = (sel_io_q == DI_SEL_IO) ? io_data : mem_rdata;

endmodule

// File: tb/tb_bus_bridge.sv
// Directed bench for bus_bridge: a transaction-level model of CPU cycles drives
// per-cycle expectations that one negedge process compares against the DUT.
module tb_bus_bridge;

  localparam logic [7:0] IO_PAGE = 8'hD0;
  localparam int         TIMEOUT = 16;
  localparam int         TW      = 5;

  logic        clk = 1'b0;
  logic        RST_N;
  logic [15:0] AD;
  logic [7:0]  DO;
  logic        WE;
  logic [7:0]  DI;
  logic        RDY;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_we;
  logic [7:0]  mem_rdata;
  logic [7:0]  io_addr;
  logic [7:0]  io_wdata;
  logic        io_we;
  logic        io_req;
  logic        io_ack;
  logic [7:0]  io_rdata;
  logic        io_err;

  bus_bridge #(
    .IO_PAGE (IO_PAGE),
    .TIMEOUT (TIMEOUT),
    .TW      (TW)
  ) dut (
    .clk       (clk),
    .RST_N     (RST_N),
    .AD        (AD),
    .DO        (DO),
    .WE        (WE),
    .DI        (DI),
    .RDY       (RDY),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .mem_rdata (mem_rdata),
    .io_addr   (io_addr),
    .io_wdata  (io_wdata),
    .io_we     (io_we),
    .io_req    (io_req),
    .io_ack    (io_ack),
    .io_rdata  (io_rdata),
    .io_err    (io_err)
  );

  always #5 clk = ~clk;

  // Local synchronous RAM attached to the memory port (read-before-write).
  logic [7:0] ram [0:65535];
  initial begin
    for (int i = 0; i < 65536; i++) ram[i] = 8'h00;
  end
  always @(posedge clk) begin
    mem_rdata <= ram[mem_addr];
    if (mem_we) ram[mem_addr] <= mem_wdata;
  end

  int errors = 0;
  int checks = 0;

  // Behavioural model state: what the CPU should observe.
  logic [7:0] model_mem [logic [15:0]];
  logic [7:0] model_io_data = 8'h00;
  logic       model_err = 1'b0;
  logic [7:0] pend_di = 8'h00;
  logic       pend_valid = 1'b0;

  logic       chk_en = 1'b0;
  logic       exp_rdy, exp_req, exp_mem_we, exp_err;
  logic       exp_di_valid = 1'b0;
  logic [7:0] exp_di;
  logic       exp_io_valid = 1'b0;
  logic [7:0] exp_io_addr, exp_io_wdata;
  logic       exp_io_we;

  int req_cycles = 0;
  int stall_cycles = 0;
  int we_pulses = 0;

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] model_read(input logic [15:0] addr);
    return model_mem.exists(addr) ? model_mem[addr] : 8'h00;
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      checkOutput("RDY", 16'(RDY), 16'(exp_rdy));
      checkOutput("io_req", 16'(io_req), 16'(exp_req));
      checkOutput("mem_we", 16'(mem_we), 16'(exp_mem_we));
      checkOutput("io_err", 16'(io_err), 16'(exp_err));
      if (exp_di_valid) checkOutput("DI", 16'(DI), 16'(exp_di));
      if (exp_io_valid) begin
        checkOutput("io_addr", 16'(io_addr), 16'(exp_io_addr));
        checkOutput("io_we", 16'(io_we), 16'(exp_io_we));
        checkOutput("io_wdata", 16'(io_wdata), 16'(exp_io_wdata));
      end
      if (io_req) req_cycles++;
      if (!RDY) stall_cycles++;
      if (mem_we) we_pulses++;
    end
  end

  task automatic begin_cycle();
    exp_di_valid = pend_valid;
    exp_di = pend_di;
    pend_valid = 1'b0;
  endtask

  task automatic end_cycle();
    @(posedge clk);
    #1;
  endtask

  // One complete CPU cycle; ack_at is the REQ cycle carrying io_ack (0 = never).
  task automatic applyStimulus(input logic [15:0] addr, input logic wr, input logic [7:0] wdata,
                               input int ack_at, input logic [7:0] rdata, input logic stray_ack);
    logic done_flag;
    done_flag = 1'b0;
    if (addr[15:8] != IO_PAGE) begin
      begin_cycle();
      AD = addr; DO = wdata; WE = wr; io_ack = 1'b0; io_rdata = 8'hEE;
      exp_rdy = 1'b1; exp_req = 1'b0; exp_mem_we = wr; exp_io_valid = 1'b0; exp_err = model_err;
      pend_di = model_read(addr);
      pend_valid = 1'b1;
      if (wr) model_mem[addr] = wdata;
      end_cycle();
    end else begin
      begin_cycle();
      AD = addr; DO = wdata; WE = wr; io_ack = 1'b0; io_rdata = 8'hEE;
      exp_rdy = 1'b0; exp_req = 1'b0; exp_mem_we = 1'b0; exp_io_valid = 1'b0; exp_err = model_err;
      end_cycle();
      for (int k = 1; k <= TIMEOUT && !done_flag; k++) begin
        begin_cycle();
        io_ack = (k == ack_at);
        io_rdata = (k == ack_at) ? rdata : 8'hEE;
        exp_rdy = 1'b0; exp_req = 1'b1; exp_mem_we = 1'b0; exp_err = model_err;
        exp_io_valid = 1'b1; exp_io_addr = addr[7:0]; exp_io_we = wr; exp_io_wdata = wdata;
        if (k == ack_at) begin
          if (!wr) model_io_data = rdata;
          done_flag = 1'b1;
        end else if (k == TIMEOUT) begin
          model_err = 1'b1;
          model_io_data = 8'hFF;
          done_flag = 1'b1;
        end
        end_cycle();
      end
      begin_cycle();
      io_ack = stray_ack; io_rdata = 8'h77;
      exp_rdy = 1'b1; exp_req = 1'b0; exp_mem_we = 1'b0; exp_err = model_err;
      pend_di = model_io_data;
      pend_valid = 1'b1;
      end_cycle();
      io_ack = 1'b0;
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int r0, s0, w0;
    RST_N = 1'b0; AD = 16'h0000; DO = 8'h00; WE = 1'b0; io_ack = 1'b0; io_rdata = 8'h00;
    #2;
    checkOutput("rst_io_req", 16'(io_req), 16'h0);
    checkOutput("rst_io_err", 16'(io_err), 16'h0);
    checkOutput("rst_rdy_mem", 16'(RDY), 16'h1);
    checkOutput("rst_io_we", 16'(io_we), 16'h0);
    checkOutput("rst_io_addr", 16'(io_addr), 16'h0);
    checkOutput("rst_io_wdata", 16'(io_wdata), 16'h0);
    AD = 16'hD000; #1;
    checkOutput("rst_rdy_io", 16'(RDY), 16'h0);
    AD = 16'h0000;
    repeat (2) @(posedge clk);
    #2 RST_N = 1'b1;
    end_cycle();
    chk_en = 1'b1;

    $display("[TB] memory write/read");
    w0 = we_pulses; s0 = stall_cycles;
    applyStimulus(16'h0200, 1'b1, 8'h5A, 0, 8'h00, 1'b0);
    applyStimulus(16'h0200, 1'b0, 8'h00, 0, 8'h00, 1'b0);
    checkOutput("mem_di_lit", 16'(DI), 16'h005A);
    checkOutput("mem_we_pulses", 16'(we_pulses - w0), 16'd1);
    checkOutput("mem_stalls", 16'(stall_cycles - s0), 16'd0);

    $display("[TB] I/O read, ack in third REQ cycle");
    r0 = req_cycles; s0 = stall_cycles;
    applyStimulus(16'hD012, 1'b0, 8'h00, 3, 8'h3C, 1'b0);
    checkOutput("io_rd_di_lit", 16'(DI), 16'h003C);
    checkOutput("io_rd_req_cycles", 16'(req_cycles - r0), 16'd3);
    checkOutput("io_rd_stalls", 16'(stall_cycles - s0), 16'd4);

    $display("[TB] I/O write, immediate ack, stray ack in DONE");
    r0 = req_cycles; s0 = stall_cycles; w0 = we_pulses;
    applyStimulus(16'hD001, 1'b1, 8'hA5, 1, 8'h99, 1'b1);
    checkOutput("io_wr_req_cycles", 16'(req_cycles - r0), 16'd1);
    checkOutput("io_wr_stalls", 16'(stall_cycles - s0), 16'd2);
    checkOutput("io_wr_mem_we", 16'(we_pulses - w0), 16'd0);
    checkOutput("io_wr_di_keeps", 16'(DI), 16'h003C);

    $display("[TB] ack coincides with timeout");
    r0 = req_cycles;
    applyStimulus(16'hD0AA, 1'b0, 8'h00, TIMEOUT, 8'h5C, 1'b0);
    checkOutput("edge_req_cycles", 16'(req_cycles - r0), 16'(TIMEOUT));
    checkOutput("edge_di_lit", 16'(DI), 16'h005C);
    checkOutput("edge_err_lit", 16'(io_err), 16'h0);

    $display("[TB] I/O timeout");
    r0 = req_cycles;
    applyStimulus(16'hD0FF, 1'b0, 8'h00, 0, 8'h00, 1'b0);
    checkOutput("to_req_cycles", 16'(req_cycles - r0), 16'd16);
    checkOutput("to_di_lit", 16'(DI), 16'h00FF);
    checkOutput("to_err_lit", 16'(io_err), 16'h1);
    applyStimulus(16'h0200, 1'b0, 8'h00, 0, 8'h00, 1'b0);
    checkOutput("to_mem_after", 16'(DI), 16'h005A);

    $display("[TB] back-to-back I/O reads");
    r0 = req_cycles;
    applyStimulus(16'hD000, 1'b0, 8'h00, 2, 8'h11, 1'b0);
    checkOutput("b2b_di0", 16'(DI), 16'h0011);
    applyStimulus(16'hD001, 1'b0, 8'h00, 1, 8'h22, 1'b0);
    checkOutput("b2b_di1", 16'(DI), 16'h0022);
    checkOutput("b2b_req_cycles", 16'(req_cycles - r0), 16'd3);
    applyStimulus(16'h0000, 1'b0, 8'h00, 0, 8'h00, 1'b0);

    $display("[TB] reset during REQ");
    begin_cycle();
    AD = 16'hD055; DO = 8'h00; WE = 1'b0; io_ack = 1'b0;
    exp_rdy = 1'b0; exp_req = 1'b0; exp_mem_we = 1'b0; exp_io_valid = 1'b0; exp_err = model_err;
    end_cycle();
    begin_cycle();
    exp_rdy = 1'b0; exp_req = 1'b1; exp_mem_we = 1'b0; exp_err = model_err;
    exp_io_valid = 1'b1; exp_io_addr = 8'h55; exp_io_we = 1'b0; exp_io_wdata = 8'h00;
    end_cycle();
    chk_en = 1'b0;
    checkOutput("mid_req_active", 16'(io_req), 16'h1);
    checkOutput("mid_err_set", 16'(io_err), 16'h1);
    #1 RST_N = 1'b0;
    #1;
    checkOutput("arst_io_req", 16'(io_req), 16'h0);
    checkOutput("arst_io_err", 16'(io_err), 16'h0);
    checkOutput("arst_rdy_io", 16'(RDY), 16'h0);
    AD = 16'h0000;
    #1;
    checkOutput("arst_rdy_mem", 16'(RDY), 16'h1);
    checkOutput("arst_di", 16'(DI), 16'(mem_rdata));
    @(posedge clk); #1;
    checkOutput("arst_io_addr", 16'(io_addr), 16'h0);
    checkOutput("arst_hold_req", 16'(io_req), 16'h0);
    RST_N = 1'b1;
    model_err = 1'b0;
    model_io_data = 8'h00;
    pend_valid = 1'b0;
    end_cycle();
    chk_en = 1'b1;
    applyStimulus(16'h0200, 1'b0, 8'h00, 0, 8'h00, 1'b0);
    checkOutput("post_rst_di", 16'(DI), 16'h005A);
    applyStimulus(16'h0000, 1'b0, 8'h00, 0, 8'h00, 1'b0);
    chk_en = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bus_bridge.md
Name: bus_bridge

Overview:
- Sits between the 65C02 core's memory bus (AD, DO, WE, DI, RDY) and the system.
- Routes each CPU cycle either to local synchronous memory (zero wait states) or to a slow external I/O page over a req/ack handshake.
- Stalls the core with RDY while an I/O access is in flight.
- Returns read data on DI in the cycle after the address, which is the core's required read timing.

Parameters:
IO_PAGE, 8'hD0, AD[15:8] value that selects the external I/O window (256 bytes)
TIMEOUT, 16, cycles io_req may stay unacknowledged before the access is aborted (min 2)
TW, 5, width of the timeout counter; must hold TIMEOUT

Ports:
clk  in  1  CPU clock, rising edge
RST_N  in  1  asynchronous active-low reset
AD  in  16  CPU address, combinational from core, held stable while RDY=0
DO  in  8  CPU write data
WE  in  1  CPU write enable
DI  out  8  read data to CPU, valid the cycle after the address
RDY  out  1  core advances at a rising edge only when RDY=1
mem_addr  out  16  local memory address, equals AD
mem_wdata  out  8  equals DO
mem_we  out  1  local memory write strobe
mem_rdata  in  8  local memory data, registered, valid one cycle after mem_addr
io_addr  out  8  latched AD[7:0] of the I/O access
io_wdata  out  8  latched DO of the I/O access
io_we  out  1  latched WE of the I/O access
io_req  out  1  I/O request, level, held until io_ack
io_ack  in  1  one-cycle acknowledge from I/O device
io_rdata  in  8  I/O read data, valid with io_ack
io_err  out  1  sticky: an I/O access timed out

Behaviour:
- io_sel = (AD[15:8] == IO_PAGE).
- Memory path:
  - mem_we = WE & ~io_sel & RDY.
  - Any cycle with RDY=1 and io_sel=0 is a complete memory cycle.
- I/O FSM states IDLE, REQ, DONE:
  - IDLE: if io_sel=1, drive RDY=0 combinationally. At the edge, latch io_addr/io_wdata/io_we from AD/DO/WE, clear the counter, go to REQ.
  - REQ: io_req=1, RDY=0, counter increments each cycle.
    - On io_ack=1: capture io_rdata into io_data_q (reads only), go to DONE. io_req is low the next cycle.
    - If the counter reaches TIMEOUT-1 without ack: set io_err=1, io_data_q=8'hFF, go to DONE.
    - If ack and timeout coincide, ack wins: normal completion, io_err unchanged.
  - DONE: RDY=1 for exactly one cycle, so the core completes the I/O cycle at this edge. Return to IDLE unconditionally. The still-present I/O address must not retrigger in DONE.
- Back-to-back I/O: the next I/O address seen in IDLE starts a new access. Minimum I/O cycle is 3 clocks with an immediate ack.
- io_ack outside REQ is ignored. io_rdata is captured only when io_we=0.
- DI select:
  - sel_io_q is registered each RDY=1 edge as (state==DONE).
  - DI = sel_io_q ? io_data_q : mem_rdata.
  - When RDY=0, sel_io_q holds.
- Reset (asynchronous, any state including mid-REQ):
  - State IDLE. io_req=0, io_we=0, io_addr=0, io_wdata=0, io_data_q=0, io_err=0, counter=0, sel_io_q=0 (DI=mem_rdata).
  - RDY is combinational: during reset it is 0 only if io_sel=1.
- io_err clears only on reset.
- Counter width TW; no wrap inside REQ because timeout triggers first.

Decomposition:
- Package bus_bridge_pkg holds:
  - state encoding constants (IDLE=2'd0, REQ=2'd1, DONE=2'd2)
  - default IO_PAGE
  - DI select constants
- One sub-module, bus_io_fsm: the state register, timeout counter, io_* latches and io_err. bus_bridge keeps the address decode, the memory path and the DI mux.

Test Plan:
- Memory read/write: write 8'h5A to 16'h0200 then read it (model RAM 1-cycle latency) -> mem_we pulses once, RDY stays 1, DI=8'h5A the cycle after the read address.
- I/O read, ack after 3 cycles with io_rdata=8'h3C at 16'hD012 -> RDY low 4 cycles then high 1, io_addr=8'h12, io_req high 3 cycles, DI=8'h3C the cycle after DONE.
- I/O write 8'hA5 to 16'hD001, ack same cycle io_req rises -> io_we=1, io_wdata=8'hA5, io_req high exactly 1 cycle, total 3-cycle access, mem_we never asserted.
- Timeout: I/O read at 16'hD0FF, no ack -> io_req high TIMEOUT cycles then drops, io_err=1 and stays 1, DI=8'hFF; the next memory access proceeds normally.
- Back-to-back I/O reads at D000 then D001 -> two separate req/ack handshakes, no retrigger in DONE, each DI correct.
- Reset asserted mid-REQ -> io_req=0 and io_err=0 immediately (no clock edge), state IDLE. After release with AD=16'h0000, RDY=1 and DI=mem_rdata.
